sll_iter: RTL and testbench
===========================

SLL_ITER -- requirements
Module: sll_iter

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset, with ports as follows.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  operand offered.
REQ-005 in_ready  output  1  unit idle and able to accept an operand.
REQ-006 a  input  64  operand to shift.
REQ-007 shamt  input  6  shift amount, 0-63.
REQ-008 rot  input  1  rotate-left select; the port is present only when SLL_ITER_ROTATE_EN is defined.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 y  output  64  shifted result.
REQ-012 busy  output  1  high in the SHIFT and DONE states.

Function
REQ-013 The FSM SHALL have three states: IDLE, SHIFT and DONE; in_ready = (state==IDLE), out_valid = (state==DONE), busy = !IDLE.
REQ-014 Acceptance SHALL occur on an edge with in_valid && in_ready: latch a into the data register, latch shamt (and rot), clear the 3-bit stage counter, go to SHIFT.
REQ-015 In SHIFT, each edge SHALL apply stage k = counter: if shamt[k], data <= data << 2^k, zero-filled from the LSB; otherwise data is held. The counter then increments.
REQ-016 After the stage-5 edge, the FSM SHALL go to DONE; out_valid is high exactly 6 clock edges after the acceptance edge, for every shamt, including 0.
REQ-017 y SHALL equal the data register at all times; y is guaranteed meaningful only while out_valid is high.
REQ-018 In DONE, y and out_valid SHALL be held stable until an edge with out_ready high, after which the FSM goes to IDLE.
REQ-019 No new operand SHALL be accepted in the DONE state, and none on the same edge that retires a result; the minimum issue interval is 8 cycles.
REQ-020 in_valid and operand changes during SHIFT or DONE SHALL be ignored and SHALL NOT alter the result.
REQ-021 The result SHALL equal a << shamt truncated to 64 bits; shamt = 63 leaves only a[0] in y[63].
REQ-022 out_ready asserted while not in DONE SHALL have no effect.

Reset
REQ-023 rst_n low SHALL immediately force state=IDLE, counter=0, data=0, latched shamt/rot=0, independent of clk.
REQ-024 Output values under reset SHALL be in_ready=1, out_valid=0, busy=0, y=0.
REQ-025 Reset asserted in SHIFT or DONE SHALL discard the operation; no result is produced after release.
REQ-026 The first acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-027 When the macro SLL_ITER_ROTATE_EN is defined, the rot port SHALL exist; with rot latched 1, each active stage SHALL rotate left by 2^k, with bits leaving the MSB entering the LSB, and result = rotl(a, shamt).
REQ-028 When SLL_ITER_ROTATE_EN is undefined, the rot port and the rotate logic SHALL be absent, and the behaviour SHALL be a pure logical shift left.

Verification
REQ-029 The bench SHALL apply a=64'h0000_0000_0000_0001, shamt=63, out_ready=1 -> out_valid 6 edges after acceptance, y=64'h8000_0000_0000_0000, in_ready returns 1 on the next edge.
REQ-030 The bench SHALL apply a=64'hDEAD_BEEF_0123_4567, shamt=0 -> y unchanged after 6 edges; busy high for 7 cycles including the DONE cycle.
REQ-031 The bench SHALL apply a=64'hFFFF_FFFF_FFFF_FFFF, shamt=36, with out_ready low for 5 cycles -> y=64'hFFFF_FFF0_0000_0000 stable throughout, out_valid held, in_ready 0, and a new in_valid ignored.
REQ-032 The bench SHALL apply a=64'h1, shamt=5, and pulse rst_n low after 3 SHIFT edges -> out_valid stays 0, y=0, in_ready=1 immediately, and no result appears after release.
REQ-033 With SLL_ITER_ROTATE_EN defined, the bench SHALL apply a=64'h8000_0000_0000_0001, shamt=4, rot=1 -> y=64'h0000_0000_0000_0018; rot=0 -> y=64'h0000_0000_0000_0010.
REQ-034 The bench SHALL run 1000 random a/shamt pairs with random out_ready back-pressure -> every y equals a << shamt, one result per accepted operand, in order.

Source files
------------

// File: rtl/sll_iter.sv
// ============================================================================
// sll_iter : iterative 64-bit shift-left unit, one log-stage per clock.
//            Optional rotate-left mode when SLL_ITER_ROTATE_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sll_iter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] a,
  input  logic [5:0]  shamt,
`ifdef SLL_ITER_ROTATE_EN
  input  logic        rot,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] y,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [2:0] LAST_STAGE = 3'd5;

  state_t      state;
  state_t      state_nxt;
  logic [63:0] data;
  logic [63:0] stage_val;
  logic [5:0]  amt;
  logic [2:0]  cnt;
  logic [5:0]  step;

  assign step = 6'd1 << cnt;

`ifdef SLL_ITER_ROTATE_EN
  logic rot_q;

  always_comb begin
    stage_val = data << step;
    if (rot_q) begin
      stage_val = (data << step) | (data >> (7'd64 - {1'b0, step}));
    end
  end
`else
  always_comb begin
    stage_val = data << step;
  end
`endif

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (cnt == LAST_STAGE) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign y = data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      data  <= 64'd0;
      amt   <= 6'd0;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            data <= a;
            amt  <= shamt;
            cnt  <= 3'd0;
          end
        end
        SHIFT: begin
          // Stage k moves the word by 2^k only when bit k of the amount is set.
          if (amt[cnt]) data <= stage_val;
          cnt <= cnt + 3'd1;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef SLL_ITER_ROTATE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rot_q <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      rot_q <= rot;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_sll_iter.sv
// Self-checking bench for sll_iter: directed vector table, hand-written
// corner sequences and randomized traffic against a behavioural model.
`default_nettype none

module tb_sll_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] a = 64'd0;
  logic [5:0]  shamt = 6'd0;
  logic        rot_i = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] y;
  logic        busy;

  int n_chk = 0;
  int n_fail = 0;

  sll_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .shamt     (shamt),
`ifdef SLL_ITER_ROTATE_EN
    .rot       (rot_i),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [63:0] a;
    logic [5:0]  sh;
    logic        r;
    logic [63:0] exp;
  } vec_t;

  function automatic logic [63:0] model(logic [63:0] av, logic [5:0] sv, logic rv);
    int s;
    s = int'(sv);
    if (rv && s != 0) return (av << s) | (av >> (64 - s));
    return av << s;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issue one operand with out_ready high; report result, latency and busy cycles.
  task automatic do_op(input logic [63:0] av, input logic [5:0] sv, input logic rv,
                       output logic [63:0] yv, output int lat, output int busy_cnt);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      tick;
      guard++;
    end
    a = av; shamt = sv; rot_i = rv; in_valid = 1'b1; out_ready = 1'b1;
    tick;
    in_valid = 1'b0;
    a = 64'h5A5A_5A5A_5A5A_5A5A; shamt = 6'd17; rot_i = ~rv;
    lat = -1; busy_cnt = 0; yv = 64'd0;
    for (int n = 0; n < 40; n++) begin
      if (busy) busy_cnt++;
      if (out_valid && lat < 0) begin
        lat = n;
        yv = y;
      end
      if (!busy) break;
      tick;
    end
  endtask

  vec_t vecs[$];
  logic [63:0] yv;
  logic [63:0] held;
  int lat, bc, seen;

  initial begin
    vecs.push_back('{64'h0000_0000_0000_0001, 6'd63, 1'b0, 64'h8000_0000_0000_0000});
    vecs.push_back('{64'hDEAD_BEEF_0123_4567, 6'd0,  1'b0, 64'hDEAD_BEEF_0123_4567});
    vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 6'd36, 1'b0, 64'hFFFF_FFF0_0000_0000});
    vecs.push_back('{64'h0123_4567_89AB_CDEF, 6'd4,  1'b0, 64'h1234_5678_9ABC_DEF0});
    vecs.push_back('{64'h0123_4567_89AB_CDEF, 6'd32, 1'b0, 64'h89AB_CDEF_0000_0000});
    vecs.push_back('{64'h8000_0000_0000_0001, 6'd1,  1'b0, 64'h0000_0000_0000_0002});
    vecs.push_back('{64'h0000_0000_0000_00FF, 6'd60, 1'b0, 64'hF000_0000_0000_0000});
    vecs.push_back('{64'hAAAA_AAAA_AAAA_AAAA, 6'd21, 1'b0, 64'h5555_5555_5540_0000});
`ifdef SLL_ITER_ROTATE_EN
    vecs.push_back('{64'h8000_0000_0000_0001, 6'd4,  1'b1, 64'h0000_0000_0000_0018});
    vecs.push_back('{64'h8000_0000_0000_0001, 6'd4,  1'b0, 64'h0000_0000_0000_0010});
`endif

    // Reset values
    #12;
    chk("reset in_ready", {63'd0, in_ready}, 64'd1);
    chk("reset out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset busy", {63'd0, busy}, 64'd0);
    chk("reset y", y, 64'd0);

    // Release between edges; the first vector is accepted on the very next edge.
    #10;
    rst_n = 1'b1;
    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].sh, vecs[i].r, yv, lat, bc);
      chk($sformatf("vec%0d y", i), yv, vecs[i].exp);
      chk($sformatf("vec%0d latency", i), 64'(lat), 64'd6);
      chk($sformatf("vec%0d busy cycles", i), 64'(bc), 64'd7);
      chk($sformatf("vec%0d in_ready after retire", i), {63'd0, in_ready}, 64'd1);
    end

    // Back-pressure: result and flags frozen, new operands ignored.
    a = 64'hFFFF_FFFF_FFFF_FFFF; shamt = 6'd36; in_valid = 1'b1; out_ready = 1'b0;
    tick;
    in_valid = 1'b0;
    repeat (6) tick;
    chk("bp out_valid", {63'd0, out_valid}, 64'd1);
    chk("bp y", y, 64'hFFFF_FFF0_0000_0000);
    held = y;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; a = {$urandom, $urandom}; shamt = 6'($urandom);
      if (y !== held || out_valid !== 1'b1 || in_ready !== 1'b0) seen++;
      tick;
    end
    chk("bp hold stable", 64'(seen), 64'd0);
    chk("bp y after hold", y, 64'hFFFF_FFF0_0000_0000);
    out_ready = 1'b1;
    tick;
    // in_valid was still high on the retire edge and must not have been taken
    chk("no accept on retire edge", {63'd0, busy}, 64'd0);
    in_valid = 1'b0;
    tick;
    chk("idle after retire", {63'd0, busy}, 64'd0);

    // Reset during SHIFT discards the operation.
    a = 64'h1; shamt = 6'd5; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    repeat (3) tick;
    rst_n = 1'b0;
    #1;
    chk("mid reset out_valid", {63'd0, out_valid}, 64'd0);
    chk("mid reset y", y, 64'd0);
    chk("mid reset in_ready", {63'd0, in_ready}, 64'd1);
    tick;
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      tick;
      if (out_valid || busy) seen++;
    end
    chk("no result after reset", 64'(seen), 64'd0);

    // Randomized traffic with back-pressure, checked in order.
    begin
      logic [63:0] q[$];
      logic [63:0] exp;
      int issued, retired, cyc;
      logic acc, ret, rv;
      issued = 0; retired = 0; cyc = 0;
      while ((issued < 1000 || q.size() != 0) && cyc < 40000) begin
        out_ready = ($urandom % 4) != 0;
        in_valid = (issued < 1000) && (($urandom % 3) != 0);
        a = {$urandom, $urandom};
        shamt = 6'($urandom);
`ifdef SLL_ITER_ROTATE_EN
        rv = 1'($urandom);
`else
        rv = 1'b0;
`endif
        rot_i = rv;
        acc = in_valid && in_ready;
        ret = out_valid && out_ready;
        if (out_valid && q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL rand spurious: got out_valid 1 expected 0");
        end
        if (ret && q.size() != 0) begin
          exp = q.pop_front();
          chk($sformatf("rand y #%0d", retired), y, exp);
          retired++;
        end
        if (acc) begin
          q.push_back(model(a, shamt, rv));
          issued++;
        end
        tick;
        cyc++;
      end
      chk("rand retired count", 64'(retired), 64'd1000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
